// File: rtl/game_state_seq.sv
// Round sequencer for the capture game: READY -> COUNTDOWN -> WAITING -> RESULT.
// Defining ROUND_STATS_EN adds saturating round_cnt / timeout_cnt outputs.
module game_state_seq #(
  parameter int unsigned TICK_CYCLES  = 100000000,
  parameter int unsigned COUNT_STEPS  = 3,
  parameter int unsigned WAIT_TIMEOUT = 500000000,
  parameter int unsigned CNT_W        = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mid_but,
  input  logic       img_done,
  output logic [1:0] state,
  output logic [3:0] count_val,
  output logic       tick,
  output logic       cap_start,
  output logic       timeout
`ifdef ROUND_STATS_EN
  ,
  output logic [7:0] round_cnt,
  output logic [7:0] timeout_cnt
`endif
);

  typedef enum logic [1:0] {
    READY     = 2'b00,
    COUNTDOWN = 2'b01,
    WAITING   = 2'b10,
    RESULT    = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'((WAIT_TIMEOUT == 0) ? 0 : WAIT_TIMEOUT - 1);
  localparam logic [3:0]       STEPS_INIT = 4'(COUNT_STEPS);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [3:0]       r_count_val;
  logic             r_tick;
  logic             r_cap_start;
  logic             r_timeout;
  logic             r_but_d;

  state_t           w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [CNT_W-1:0] w_wait_nx;
  logic [3:0]       w_count_nx;
  logic             w_tick_nx;
  logic             w_cap_nx;
  logic             w_timeout_nx;
  logic             w_press;

  assign w_press = mid_but & ~r_but_d;

  // r_but_d resets high so a button held through reset never counts as a press
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= READY;
      r_cnt       <= '0;
      r_wait_cnt  <= '0;
      r_count_val <= 4'd0;
      r_tick      <= 1'b0;
      r_cap_start <= 1'b0;
      r_timeout   <= 1'b0;
      r_but_d     <= 1'b1;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_wait_cnt  <= w_wait_nx;
      r_count_val <= w_count_nx;
      r_tick      <= w_tick_nx;
      r_cap_start <= w_cap_nx;
      r_timeout   <= w_timeout_nx;
      r_but_d     <= mid_but;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_wait_nx    = r_wait_cnt;
    w_count_nx   = r_count_val;
    w_tick_nx    = 1'b0;
    w_cap_nx     = 1'b0;
    w_timeout_nx = r_timeout;
    case (r_state)
      READY: begin
        w_count_nx = 4'd0;
        if (w_press) begin
          w_state_nx = COUNTDOWN;
          w_count_nx = STEPS_INIT;
          w_cnt_nx   = '0;
        end
      end
      COUNTDOWN: begin
        // abort beats a tick landing on the same edge
        if (w_press) begin
          w_state_nx = READY;
          w_count_nx = 4'd0;
          w_cnt_nx   = '0;
        end else if (r_cnt == TICK_LAST) begin
          w_cnt_nx   = '0;
          w_tick_nx  = 1'b1;
          w_count_nx = (r_count_val == 4'd0) ? 4'd0 : r_count_val - 4'd1;
          if (r_count_val <= 4'd1) begin
            w_state_nx = WAITING;
            w_cap_nx   = 1'b1;
            w_wait_nx  = '0;
          end
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      WAITING: begin
        if (img_done) begin
          w_state_nx   = RESULT;
          w_timeout_nx = 1'b0;
        end else if ((WAIT_TIMEOUT != 0) && (r_wait_cnt == WAIT_LAST)) begin
          w_state_nx   = RESULT;
          w_timeout_nx = 1'b1;
        end else if (WAIT_TIMEOUT != 0) begin
          w_wait_nx = r_wait_cnt + CNT_W'(1);
        end
      end
      RESULT: begin
        if (w_press) begin
          w_state_nx   = READY;
          w_timeout_nx = 1'b0;
        end
      end
      default: begin
        w_state_nx   = READY;
        w_count_nx   = 4'd0;
        w_timeout_nx = 1'b0;
      end
    endcase
  end

  assign state     = r_state;
  assign count_val = r_count_val;
  assign tick      = r_tick;
  assign cap_start = r_cap_start;
  assign timeout   = r_timeout;

`ifdef ROUND_STATS_EN
  logic [7:0] r_round_cnt;
  logic [7:0] r_timeout_cnt;
  logic       w_round_evt;
  logic       w_to_evt;

  assign w_round_evt = (r_state == WAITING) && (w_state_nx == RESULT);
  assign w_to_evt    = w_round_evt && w_timeout_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_round_cnt   <= 8'd0;
      r_timeout_cnt <= 8'd0;
    end else begin
      if (w_round_evt && (r_round_cnt != 8'hFF))
        r_round_cnt <= r_round_cnt + 8'd1;
      if (w_to_evt && (r_timeout_cnt != 8'hFF))
        r_timeout_cnt <= r_timeout_cnt + 8'd1;
    end
  end

  assign round_cnt   = r_round_cnt;
  assign timeout_cnt = r_timeout_cnt;
`endif

endmodule

// File: tb/tb_game_state_seq.sv
// Scoreboard bench for game_state_seq: stimulus queues expected output events,
// a monitor pops them whenever the outputs change or a pulse fires.
module tb_game_state_seq;

  localparam logic [1:0] ST_READY = 2'b00;
  localparam logic [1:0] ST_CD    = 2'b01;
  localparam logic [1:0] ST_WAIT  = 2'b10;
  localparam logic [1:0] ST_RES   = 2'b11;

  logic       clk;
  logic       rst;
  logic       mid_but;
  logic       img_done;
  logic [1:0] state;
  logic [3:0] count_val;
  logic       tick;
  logic       cap_start;
  logic       timeout;
`ifdef ROUND_STATS_EN
  logic [7:0] round_cnt;
  logic [7:0] timeout_cnt;
`endif

  game_state_seq #(
    .TICK_CYCLES (4),
    .COUNT_STEPS (3),
    .WAIT_TIMEOUT(20),
    .CNT_W       (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mid_but    (mid_but),
    .img_done   (img_done),
    .state      (state),
    .count_val  (count_val),
    .tick       (tick),
    .cap_start  (cap_start),
    .timeout    (timeout)
`ifdef ROUND_STATS_EN
    ,
    .round_cnt  (round_cnt),
    .timeout_cnt(timeout_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nCompared   = 0;
  int nMismatched = 0;

  // event layout: {cycle[31:0], state[1:0], count_val[3:0], tick, cap_start, timeout}
  logic [40:0] expQ[$];
  logic        monEn    = 1'b0;
  logic        havePrev = 1'b0;
  logic [6:0]  prevTup;
  logic [6:0]  curTup;
  logic [40:0] actEvt;
  logic [40:0] expEvt;

  task automatic checkOutput(input string name, input logic [40:0] act, input logic [40:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (monEn) begin
      curTup = {state, count_val, timeout};
      if (!havePrev || (curTup != prevTup) || tick || cap_start) begin
        actEvt = {32'(cyc), state, count_val, tick, cap_start, timeout};
        if (expQ.size() == 0) begin
          nCompared++;
          nMismatched++;
          $display("[TB] FAIL unexpected_event: got 0x%h expected no event", actEvt);
        end else begin
          expEvt = expQ.pop_front();
          checkOutput($sformatf("event@cyc%0d", cyc), actEvt, expEvt);
        end
      end
      prevTup  = curTup;
      havePrev = 1'b1;
    end
  end

  task automatic applyStimulus(input logic but, input logic done);
    mid_but  = but;
    img_done = done;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitUntil(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic expectEvt(input int c, input logic [1:0] st, input logic [3:0] cv,
                           input logic tk, input logic cs, input logic to);
    expQ.push_back({32'(c), st, cv, tk, cs, to});
  endtask

  // full countdown from a press issued in cycle c
  task automatic expectCountdown(input int c);
    expectEvt(c + 1,  ST_CD,   4'd3, 1'b0, 1'b0, 1'b0);
    expectEvt(c + 5,  ST_CD,   4'd2, 1'b1, 1'b0, 1'b0);
    expectEvt(c + 9,  ST_CD,   4'd1, 1'b1, 1'b0, 1'b0);
    expectEvt(c + 13, ST_WAIT, 4'd0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic pressToReady();
    int q;
    q = cyc;
    applyStimulus(1'b1, 1'b0);
    expectEvt(q + 1, ST_READY, 4'd0, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0);
    waitCycles(2);
  endtask

  initial begin
    int c;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    waitCycles(3);

    c = cyc;
    rst   = 1'b0;
    monEn = 1'b1;
    expectEvt(c + 1, ST_READY, 4'd0, 1'b0, 1'b0, 1'b0);
    waitCycles(5);

    $display("[TB] held press, full countdown, WAITING timeout");
    c = cyc;
    applyStimulus(1'b1, 1'b0);
    expectCountdown(c);
    expectEvt(c + 33, ST_RES, 4'd0, 1'b0, 1'b0, 1'b1);
    waitUntil(c + 50);
    applyStimulus(1'b0, 1'b0);
    waitCycles(2);
    pressToReady();

    $display("[TB] img_done five cycles into WAITING");
    c = cyc;
    applyStimulus(1'b1, 1'b0);
    expectCountdown(c);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0);
    waitUntil(c + 18);
    applyStimulus(1'b0, 1'b1);
    expectEvt(c + 19, ST_RES, 4'd0, 1'b0, 1'b0, 1'b0);
    waitCycles(3);
    applyStimulus(1'b0, 1'b0);
    waitCycles(2);
    pressToReady();

    $display("[TB] abort six cycles into COUNTDOWN");
    c = cyc;
    applyStimulus(1'b1, 1'b0);
    expectEvt(c + 1, ST_CD, 4'd3, 1'b0, 1'b0, 1'b0);
    expectEvt(c + 5, ST_CD, 4'd2, 1'b1, 1'b0, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0);
    waitUntil(c + 6);
    applyStimulus(1'b1, 1'b0);
    expectEvt(c + 7, ST_READY, 4'd0, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0);
    waitCycles(2);

    $display("[TB] abort coincident with a tick");
    c = cyc;
    applyStimulus(1'b1, 1'b0);
    expectEvt(c + 1, ST_CD, 4'd3, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0);
    waitUntil(c + 4);
    applyStimulus(1'b1, 1'b0);
    expectEvt(c + 5, ST_READY, 4'd0, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0);
    waitCycles(2);

    $display("[TB] img_done coincident with timeout");
    c = cyc;
    applyStimulus(1'b1, 1'b0);
    expectCountdown(c);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0);
    waitUntil(c + 32);
    applyStimulus(1'b0, 1'b1);
    expectEvt(c + 33, ST_RES, 4'd0, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0);
    waitCycles(1);
    pressToReady();

`ifdef ROUND_STATS_EN
    checkOutput("round_cnt_after_3", {33'd0, round_cnt}, 41'd3);
    checkOutput("timeout_cnt_after_3", {33'd0, timeout_cnt}, 41'd1);
`endif

    $display("[TB] button held through reset, then reset mid-COUNTDOWN");
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0);
    waitCycles(2);
    rst = 1'b0;
    waitCycles(3);
    applyStimulus(1'b0, 1'b0);
    waitCycles(2);
    c = cyc;
    applyStimulus(1'b1, 1'b0);
    expectEvt(c + 1, ST_CD, 4'd3, 1'b0, 1'b0, 1'b0);
    expectEvt(c + 5, ST_CD, 4'd2, 1'b1, 1'b0, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0);
    waitUntil(c + 6);
    rst = 1'b1;
    expectEvt(c + 7, ST_READY, 4'd0, 1'b0, 1'b0, 1'b0);
    waitCycles(2);
    rst = 1'b0;
    waitCycles(2);

`ifdef ROUND_STATS_EN
    $display("[TB] 300 quick rounds for counter saturation");
    for (int r = 0; r < 300; r++) begin
      c = cyc;
      applyStimulus(1'b1, 1'b0);
      expectCountdown(c);
      waitCycles(1);
      applyStimulus(1'b0, 1'b0);
      waitUntil(c + 13);
      applyStimulus(1'b0, 1'b1);
      expectEvt(c + 14, ST_RES, 4'd0, 1'b0, 1'b0, 1'b0);
      waitCycles(1);
      applyStimulus(1'b0, 1'b0);
      pressToReady();
    end
    checkOutput("round_cnt_saturated", {33'd0, round_cnt}, 41'd255);
    checkOutput("timeout_cnt_after_reset", {33'd0, timeout_cnt}, 41'd0);
`endif

    waitCycles(5);
    while (expQ.size() != 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL missing_event: got nothing expected 0x%h", expQ.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
